// File: rtl/svreal_avg_pkg.sv
// Shared helpers for the fixed-point averaging and format-alignment stages:
// exponent alignment, accumulator sizing and signed saturation limits.
package svreal_avg_pkg;

    // Widest intermediate the saturation helpers can describe.
    localparam int MAX_W = 256;

    function automatic int align_shift(input int in_exp, input int log2_n, input int out_exp);
        return (in_exp - log2_n) - out_exp;
    endfunction

    function automatic int acc_width(input int in_width, input int log2_n);
        return in_width + log2_n;
    endfunction

    function automatic int abs_int(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_hi(input int width);
        logic signed [MAX_W-1:0] one;
        one = 1;
        return (one <<< (width - 1)) - one;
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_lo(input int width);
        logic signed [MAX_W-1:0] one;
        one = 1;
        return -(one <<< (width - 1));
    endfunction

endpackage

// File: rtl/svreal_align_sat.sv
// Combinational exponent alignment (shift by SHIFT, floor on right shifts)
// followed by saturation to a signed OUT_W-bit code.
module svreal_align_sat
    import svreal_avg_pkg::*;
#(
    parameter int IN_W  = 18,
    parameter int SHIFT = 0,
    parameter int OUT_W = 18
) (
    input  logic signed [IN_W-1:0]  in_code,
    output logic signed [OUT_W-1:0] out_code,
    output logic                    clamped
);

    localparam int UP    = (SHIFT > 0) ? SHIFT : 0;
    localparam int EXT_W = (((IN_W + UP) > OUT_W) ? (IN_W + UP) : OUT_W) + 1;
    localparam logic signed [EXT_W-1:0] HI = EXT_W'(sat_hi(OUT_W));
    localparam logic signed [EXT_W-1:0] LO = EXT_W'(sat_lo(OUT_W));

    if (EXT_W > MAX_W) begin : g_width_check
        $error("svreal_align_sat: intermediate width exceeds MAX_W");
    end

    logic signed [EXT_W-1:0] in_ext;
    logic signed [EXT_W-1:0] aligned;

    // Headroom of UP+1 bits means a left shift never loses bits before the clamp.
    assign in_ext = {{(EXT_W - IN_W){in_code[IN_W-1]}}, in_code};

    if (SHIFT >= 0) begin : g_left
        assign aligned = in_ext <<< SHIFT;
    end else begin : g_right
        assign aligned = in_ext >>> (-SHIFT);
    end

    always_comb begin
        out_code = aligned[OUT_W-1:0];
        clamped  = 1'b0;
        if (aligned > HI) begin
            out_code = HI[OUT_W-1:0];
            clamped  = 1'b1;
        end else if (aligned < LO) begin
            out_code = LO[OUT_W-1:0];
            clamped  = 1'b1;
        end
    end

endmodule

// File: rtl/svreal_block_avg.sv
// Streaming block averager: sums 2^LOG2_N accepted samples and emits the sum
// reinterpreted at exponent IN_EXP-LOG2_N, aligned and saturated to OUT_EXP.
module svreal_block_avg
    import svreal_avg_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int IN_EXP    = -8,
    parameter int OUT_WIDTH = 18,
    parameter int OUT_EXP   = -10,
    parameter int LOG2_N    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic signed [IN_WIDTH-1:0]  in_value,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [OUT_WIDTH-1:0] out_value,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sat
);

    localparam int ACC_WIDTH = acc_width(IN_WIDTH, LOG2_N);
    localparam int SHIFT     = align_shift(IN_EXP, LOG2_N, OUT_EXP);

    if (LOG2_N < 1 || LOG2_N > 8) begin : g_log2n_check
        $error("svreal_block_avg: LOG2_N must be in 1..8");
    end
    if (abs_int(SHIFT) > IN_WIDTH + LOG2_N + OUT_WIDTH) begin : g_shift_check
        $error("svreal_block_avg: alignment shift out of range");
    end

    logic signed [ACC_WIDTH-1:0] acc_reg, acc_next;
    logic [LOG2_N-1:0]           count_reg, count_next;
    logic signed [OUT_WIDTH-1:0] out_value_reg, out_value_next;
    logic                        out_valid_reg, out_valid_next;
    logic                        sat_reg, sat_next;

    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [OUT_WIDTH-1:0] result;
    logic                        result_clamped;
    logic                        last_sample;
    logic                        accept;
    logic                        load;

    assign sum         = acc_reg + {{LOG2_N{in_value[IN_WIDTH-1]}}, in_value};
    assign last_sample = &count_reg;
    // Only the block-completing sample has to wait for the result slot.
    assign in_ready    = !(last_sample && out_valid_reg && !out_ready);
    assign accept      = in_valid && in_ready;
    assign load        = accept && last_sample && !clear;

    svreal_align_sat #(
        .IN_W  (ACC_WIDTH),
        .SHIFT (SHIFT),
        .OUT_W (OUT_WIDTH)
    ) u_align_sat (
        .in_code  (sum),
        .out_code (result),
        .clamped  (result_clamped)
    );

    always_comb begin
        acc_next       = acc_reg;
        count_next     = count_reg;
        out_value_next = out_value_reg;
        out_valid_next = out_valid_reg;
        sat_next       = sat_reg;

        if (clear) begin
            acc_next   = '0;
            count_next = '0;
        end else if (accept) begin
            if (last_sample) begin
                acc_next   = '0;
                count_next = '0;
            end else begin
                acc_next   = sum;
                count_next = count_reg + LOG2_N'(1);
            end
        end

        // A fresh result overrides a same-cycle consumption.
        if (load) begin
            out_value_next = result;
            out_valid_next = 1'b1;
            sat_next       = sat_reg | result_clamped;
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg       <= '0;
            count_reg     <= '0;
            out_value_reg <= '0;
            out_valid_reg <= 1'b0;
            sat_reg       <= 1'b0;
        end else begin
            acc_reg       <= acc_next;
            count_reg     <= count_next;
            out_value_reg <= out_value_next;
            out_valid_reg <= out_valid_next;
            sat_reg       <= sat_next;
        end
    end

    assign out_value = out_value_reg;
    assign out_valid = out_valid_reg;
    assign sat       = sat_reg;

endmodule

// File: tb/tb_svreal_block_avg.sv
// Four averagers in different output formats share one input stream and are
// checked against directed vectors and a block-level reference model.
module tb_svreal_block_avg;

    localparam int N    = 4;
    localparam int NCFG = 4;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic in_valid;
    logic out_ready;
    logic signed [15:0] in_value;

    logic rdy0, rdy1, rdy2, rdy3;
    logic ov0, ov1, ov2, ov3;
    logic sat0, sat1, sat2, sat3;
    logic signed [17:0] val0, val2, val3;
    logic signed [11:0] val1;

    always #5 clk = ~clk;

    // cfg0: defaults (s=0); cfg1: 12-bit output; cfg2: OUT_EXP=-7 (s=-3); cfg3: OUT_EXP=-12 (s=+2)
    svreal_block_avg u_def (
        .clk(clk), .rst(rst), .clear(clear), .in_value(in_value), .in_valid(in_valid),
        .in_ready(rdy0), .out_value(val0), .out_valid(ov0), .out_ready(out_ready), .sat(sat0));
    svreal_block_avg #(.OUT_WIDTH(12)) u_nar (
        .clk(clk), .rst(rst), .clear(clear), .in_value(in_value), .in_valid(in_valid),
        .in_ready(rdy1), .out_value(val1), .out_valid(ov1), .out_ready(out_ready), .sat(sat1));
    svreal_block_avg #(.OUT_EXP(-7)) u_shr (
        .clk(clk), .rst(rst), .clear(clear), .in_value(in_value), .in_valid(in_valid),
        .in_ready(rdy2), .out_value(val2), .out_valid(ov2), .out_ready(out_ready), .sat(sat2));
    svreal_block_avg #(.OUT_EXP(-12)) u_shl (
        .clk(clk), .rst(rst), .clear(clear), .in_value(in_value), .in_valid(in_valid),
        .in_ready(rdy3), .out_value(val3), .out_valid(ov3), .out_ready(out_ready), .sat(sat3));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: current block as a list of samples plus one result slot per format.
    longint blk[$];
    bit     m_valid;
    longint m_val [NCFG];
    bit     m_sat [NCFG];

    function automatic int cfg_w(input int c);
        return (c == 1) ? 12 : 18;
    endfunction

    function automatic int cfg_s(input int c);
        case (c)
            2:       return -3;
            3:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic longint dut_val(input int c);
        case (c)
            0:       return longint'(val0);
            1:       return longint'(val1);
            2:       return longint'(val2);
            default: return longint'(val3);
        endcase
    endfunction

    function automatic bit dut_ov(input int c);
        case (c)
            0: return ov0; 1: return ov1; 2: return ov2; default: return ov3;
        endcase
    endfunction

    function automatic bit dut_sat(input int c);
        case (c)
            0: return sat0; 1: return sat1; 2: return sat2; default: return sat3;
        endcase
    endfunction

    function automatic bit dut_rdy(input int c);
        case (c)
            0: return rdy0; 1: return rdy1; 2: return rdy2; default: return rdy3;
        endcase
    endfunction

    // Sum scaled by 2^s (floor division for negative s), then clamped to w bits.
    function automatic longint ref_avg(input longint total, input int s, input int w, output bit clamp);
        longint v, d, hi, lo;
        if (s >= 0) begin
            v = total * (longint'(1) <<< s);
        end else begin
            d = longint'(1) <<< (-s);
            v = total / d;
            if (total < 0 && (total % d) != 0) v = v - 1;
        end
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        clamp = 1'b0;
        if (v > hi) begin v = hi; clamp = 1'b1; end
        if (v < lo) begin v = lo; clamp = 1'b1; end
        return v;
    endfunction

    task automatic chk(input string name, input int c, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[cfg%0d]: got %0d, expected %0d at %0t", name, c, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        blk.delete();
        m_valid = 1'b0;
        for (int c = 0; c < NCFG; c++) begin
            m_val[c] = 0;
            m_sat[c] = 1'b0;
        end
    endtask

    function automatic bit model_ready(input bit ordy);
        return !(blk.size() == N - 1 && m_valid && !ordy);
    endfunction

    task automatic model_edge(input bit v, input longint d, input bit clr, input bit ordy);
        bit     rdy;
        bit     load;
        bit     cl;
        longint total;
        rdy   = model_ready(ordy);
        load  = 1'b0;
        total = 0;
        if (clr) begin
            blk.delete();
        end else if (v && rdy) begin
            blk.push_back(d);
            if (blk.size() == N) begin
                foreach (blk[i]) total += blk[i];
                blk.delete();
                load = 1'b1;
                for (int c = 0; c < NCFG; c++) begin
                    m_val[c] = ref_avg(total, cfg_s(c), cfg_w(c), cl);
                    m_sat[c] = m_sat[c] | cl;
                end
                $display("result: sum=%0d -> %0d / %0d / %0d / %0d",
                         total, m_val[0], m_val[1], m_val[2], m_val[3]);
            end
        end
        if (load) m_valid = 1'b1;
        else if (m_valid && ordy) m_valid = 1'b0;
    endtask

    task automatic check_outputs();
        for (int c = 0; c < NCFG; c++) begin
            chk("out_valid", c, longint'(dut_ov(c)), longint'(m_valid));
            chk("out_value", c, dut_val(c), m_val[c]);
            chk("sat", c, longint'(dut_sat(c)), longint'(m_sat[c]));
        end
    endtask

    task automatic cycle(input bit v, input int d, input bit clr, input bit ordy, output bit rdy_seen);
        @(negedge clk);
        in_valid  = v;
        in_value  = 16'(d);
        clear     = clr;
        out_ready = ordy;
        #1;
        for (int c = 0; c < NCFG; c++) chk("in_ready", c, longint'(dut_rdy(c)), longint'(model_ready(ordy)));
        rdy_seen = rdy0;
        model_edge(v, longint'(in_value), clr, ordy);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    typedef struct {
        bit v; int d; bit clr; bit ordy;
        bit e_rdy; bit e_ov; int e_def; int e_nar; int e_shr; bit e_satn;
    } vec_t;

    vec_t tbl[$];

    initial begin
        bit r;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_value = '0;
        model_reset();
        #3;
        check_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        //                   v  d       clr ordy rdy ov def      nar    shr     satn
        tbl.push_back(vec_t'{1, 315,    0, 1,  1, 0, 0,       0,     0,      0});
        tbl.push_back(vec_t'{1, 1167,   0, 1,  1, 0, 0,       0,     0,      0});
        tbl.push_back(vec_t'{1, 315,    0, 1,  1, 0, 0,       0,     0,      0});
        tbl.push_back(vec_t'{1, 1167,   0, 1,  1, 1, 2964,    2047,  370,    1});
        tbl.push_back(vec_t'{0, 0,      0, 1,  1, 0, 2964,    2047,  370,    1});
        tbl.push_back(vec_t'{1, -315,   0, 1,  1, 0, 2964,    2047,  370,    1});
        tbl.push_back(vec_t'{1, -1167,  0, 1,  1, 0, 2964,    2047,  370,    1});
        tbl.push_back(vec_t'{1, -315,   0, 1,  1, 0, 2964,    2047,  370,    1});
        tbl.push_back(vec_t'{1, -1167,  0, 1,  1, 1, -2964,   -2048, -371,   1});
        for (int i = 0; i < 3; i++)
            tbl.push_back(vec_t'{1, -32768, 0, 1, 1, 0, -2964, -2048, -371, 1});
        tbl.push_back(vec_t'{1, -32768, 0, 1,  1, 1, -131072, -2048, -16384, 1});
        for (int i = 0; i < 3; i++)
            tbl.push_back(vec_t'{1, 32767, 0, 1, 1, 0, -131072, -2048, -16384, 1});
        tbl.push_back(vec_t'{1, 32767,  0, 1,  1, 1, 131068,  2047,  16383,  1});
        tbl.push_back(vec_t'{1, 100,    0, 0,  1, 1, 131068,  2047,  16383,  1});
        tbl.push_back(vec_t'{1, 200,    0, 0,  1, 1, 131068,  2047,  16383,  1});
        tbl.push_back(vec_t'{1, 300,    0, 0,  1, 1, 131068,  2047,  16383,  1});
        tbl.push_back(vec_t'{1, 400,    0, 0,  0, 1, 131068,  2047,  16383,  1});
        tbl.push_back(vec_t'{1, 400,    0, 0,  0, 1, 131068,  2047,  16383,  1});
        tbl.push_back(vec_t'{1, 400,    0, 1,  1, 1, 1000,    1000,  125,    1});
        tbl.push_back(vec_t'{0, 0,      0, 1,  1, 0, 1000,    1000,  125,    1});
        tbl.push_back(vec_t'{1, 5000,   0, 1,  1, 0, 1000,    1000,  125,    1});
        tbl.push_back(vec_t'{1, 5000,   0, 1,  1, 0, 1000,    1000,  125,    1});
        tbl.push_back(vec_t'{1, 7,      1, 1,  1, 0, 1000,    1000,  125,    1});
        tbl.push_back(vec_t'{1, 8,      0, 1,  1, 0, 1000,    1000,  125,    1});
        tbl.push_back(vec_t'{1, 16,     0, 1,  1, 0, 1000,    1000,  125,    1});
        tbl.push_back(vec_t'{1, 24,     0, 1,  1, 0, 1000,    1000,  125,    1});
        tbl.push_back(vec_t'{1, 32,     0, 1,  1, 1, 80,      80,    10,     1});
        tbl.push_back(vec_t'{0, 0,      1, 0,  1, 1, 80,      80,    10,     1});
        tbl.push_back(vec_t'{0, 0,      0, 1,  1, 0, 80,      80,    10,     1});
        for (int i = 0; i < 3; i++)
            tbl.push_back(vec_t'{1, 1, 0, 1, 1, 0, 80, 80, 10, 1});
        tbl.push_back(vec_t'{1, 1,      1, 1,  1, 0, 80,      80,    10,     1});
        for (int i = 0; i < 3; i++)
            tbl.push_back(vec_t'{1, 4, 0, 1, 1, 0, 80, 80, 10, 1});
        tbl.push_back(vec_t'{1, 4,      0, 1,  1, 1, 16,      16,    2,      1});

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].clr, tbl[i].ordy, r);
            chk("tbl_in_ready", i, longint'(r), longint'(tbl[i].e_rdy));
            chk("tbl_out_valid", i, longint'(ov0), longint'(tbl[i].e_ov));
            chk("tbl_def_value", i, dut_val(0), longint'(tbl[i].e_def));
            chk("tbl_nar_value", i, dut_val(1), longint'(tbl[i].e_nar));
            chk("tbl_shr_value", i, dut_val(2), longint'(tbl[i].e_shr));
            chk("tbl_nar_sat", i, longint'(sat1), longint'(tbl[i].e_satn));
            $display("row %0d: v=%0d d=%0d clr=%0d ordy=%0d -> rdy=%0d ov=%0d val=%0d/%0d/%0d sat=%0d",
                     i, tbl[i].v, tbl[i].d, tbl[i].clr, tbl[i].ordy, r, ov0, val0, val1, val2, sat1);
        end

        // Asynchronous reset in the middle of a block, away from any clock edge.
        cycle(1, 50, 0, 0, r);
        cycle(1, 60, 0, 0, r);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("async_rst_nar_sat", 1, longint'(sat1), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 10, 0, 1, r);
        cycle(1, 20, 0, 1, r);
        cycle(1, 30, 0, 1, r);
        cycle(1, 40, 0, 1, r);
        chk("post_rst_block", 0, dut_val(0), 100);
        chk("post_rst_valid", 0, longint'(ov0), 1);

        // Randomised traffic with backpressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7,
                  int'($urandom_range(0, 65535)) - 32768,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 6,
                  r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
